drop_tick_rx: RTL and testbench

Fast-domain receiver for the divided gravity clock `clk` produced by the one-second divider. It synchronises that slow square wave into the `clock` domain and treats every edge (rise or fall) as one gravity event. Events, plus optional soft-drop events, are queued in a saturating pending counter. The counter is presented to the game FSM through a `step_req`/`step_ack` handshake, so no drop step is lost while the FSM is busy.

---
 rtl/tetris_timing_pkg.sv | 16 +
 rtl/edge_sync.sv | 52 +++++
 rtl/drop_tick_rx.sv | 84 ++++++++
 tb/tb_drop_tick_rx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_timing_pkg.sv
// Shared timing constants for the gravity divider and its fast-domain receiver.
package tetris_timing_pkg;

  localparam int unsigned CLK_HZ           = 25000000;
  localparam int unsigned GRAVITY_HALF     = 25000000;
  localparam int unsigned SOFT_DIV_DEFAULT = 2500000;
  localparam int unsigned SYNC_WARMUP      = 3;

  typedef enum logic [1:0] {
    PEND_HOLD,
    PEND_INC,
    PEND_DEC,
    PEND_SAT
  } pend_op_e;

endpackage

// File: rtl/edge_sync.sv
// Synchronises the slow gravity square wave and flags each edge once the
// warm-up after reset has completed.
module edge_sync
  import tetris_timing_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic slow_clk,
  output logic e_slow
);

  localparam int unsigned WARM_W = 2;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_WARMUP - 1);

  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic              prev_q, prev_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic              armed_q, armed_d;

  always_comb begin
    s1_d    = slow_clk;
    s2_d    = s1_q;
    prev_d  = s2_q;
    warm_d  = warm_q;
    armed_d = armed_q;
    // prev follows s2 silently until armed, so the level at release is not an edge
    if (!armed_q) begin
      warm_d = warm_q + WARM_W'(1);
      if (warm_q == WARM_LAST) armed_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      warm_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      warm_q  <= warm_d;
      armed_q <= armed_d;
    end
  end

  assign e_slow = (s2_q ^ prev_q) & armed_q;

endmodule

// File: rtl/drop_tick_rx.sv
// Gravity/soft-drop event receiver: queues drop steps in a saturating counter
// and hands them to the game FSM through a req/ack handshake.
module drop_tick_rx
  import tetris_timing_pkg::*;
#(
  parameter int unsigned SOFT_DIV = SOFT_DIV_DEFAULT,
  parameter int unsigned MAX_PEND = 3,
  localparam int unsigned PEND_W  = $clog2(MAX_PEND + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              slow_clk,
  input  logic              soft_drop,
  input  logic              pause,
  input  logic              step_ack,
  input  logic              clr_overrun,
  output logic              step_req,
  output logic [PEND_W-1:0] pending,
  output logic              overrun
);

  localparam int unsigned SC_W = $clog2(SOFT_DIV);
  localparam logic [SC_W-1:0]   SC_LAST  = SC_W'(SOFT_DIV - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

  logic              e_slow;
  logic              counting;
  logic              e_soft;
  logic              ev;
  logic              ack_v;
  pend_op_e          op;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              overrun_q, overrun_d;

  edge_sync u_edge_sync (
    .clock    (clock),
    .reset    (reset),
    .slow_clk (slow_clk),
    .e_slow   (e_slow)
  );

  assign step_req = (pend_q != '0) & ~pause;

  always_comb begin
    counting  = soft_drop & ~pause;
    e_soft    = counting & (sc_q == SC_LAST);
    ev        = (e_slow | e_soft) & ~pause;
    ack_v     = step_ack & step_req;
    sc_d      = '0;
    op        = PEND_HOLD;
    pend_d    = pend_q;
    overrun_d = overrun_q & ~clr_overrun;

    if (counting && !e_soft) sc_d = sc_q + SC_W'(1);

    // a simultaneous event and ack cancel out
    if (ev && !ack_v)      op = (pend_q == PEND_MAX) ? PEND_SAT : PEND_INC;
    else if (!ev && ack_v) op = PEND_DEC;

    unique case (op)
      PEND_INC: pend_d    = pend_q + PEND_W'(1);
      PEND_DEC: pend_d    = pend_q - PEND_W'(1);
      PEND_SAT: overrun_d = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sc_q      <= '0;
      pend_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      sc_q      <= sc_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending = pend_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_drop_tick_rx.sv
// Bench for drop_tick_rx: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a sample-history model.
module tb_drop_tick_rx;

  localparam int unsigned SOFT_DIV = 4;
  localparam int unsigned MAX_PEND = 3;
  localparam int unsigned PEND_W   = $clog2(MAX_PEND + 1);

  logic              clock;
  logic              reset;
  logic              slow_clk;
  logic              soft_drop;
  logic              pause;
  logic              step_ack;
  logic              clr_overrun;
  logic              step_req;
  logic [PEND_W-1:0] pending;
  logic              overrun;

  int n_checks = 0;
  int n_errors = 0;

  drop_tick_rx #(
    .SOFT_DIV (SOFT_DIV),
    .MAX_PEND (MAX_PEND)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .slow_clk    (slow_clk),
    .soft_drop   (soft_drop),
    .pause       (pause),
    .step_ack    (step_ack),
    .clr_overrun (clr_overrun),
    .step_req    (step_req),
    .pending     (pending),
    .overrun     (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  // Reference model: slow_clk samples per edge since reset release, soft run
  // length, and the pending/overrun rules applied with plain integers.
  int m_pend;
  bit m_ovr;
  int m_edges;
  int m_run;
  bit hist[$];
  bit ev_s, ev_f, m_ev, m_ack, m_req, ovr_set;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pend  = 0;
      m_ovr   = 1'b0;
      m_edges = 0;
      m_run   = 0;
      hist.delete();
    end else begin
      m_edges++;
      hist.push_back(slow_clk);
      // an input change sampled at edge n-2 becomes a step at edge n, armed from edge 4
      ev_s = (m_edges >= 4) && (hist[m_edges-3] != hist[m_edges-4]);
      if (soft_drop && !pause) begin
        m_run++;
        ev_f = (m_run % SOFT_DIV) == 0;
      end else begin
        m_run = 0;
        ev_f  = 1'b0;
      end
      m_ev    = (ev_s || ev_f) && !pause;
      m_req   = (m_pend != 0) && !pause;
      m_ack   = step_ack && m_req;
      ovr_set = 1'b0;
      if (m_ev && m_ack)               ;
      else if (m_ev && m_pend < MAX_PEND) m_pend++;
      else if (m_ev)                   ovr_set = 1'b1;
      else if (m_ack)                  m_pend--;
      if (ovr_set)          m_ovr = 1'b1;
      else if (clr_overrun) m_ovr = 1'b0;
    end
  end

  always @(posedge clock) begin
    #1;
    chk("cyc_pending", 32'(pending), 32'(m_pend));
    chk("cyc_step_req", 32'(step_req), 32'((m_pend != 0) && !pause));
    chk("cyc_overrun", 32'(overrun), 32'(m_ovr));
  end

  int exp3[4] = '{1, 2, 3, 3};

  initial begin
    reset       = 1'b1;
    slow_clk    = 1'b1;
    soft_drop   = 1'b0;
    pause       = 1'b0;
    step_ack    = 1'b0;
    clr_overrun = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_pending", 32'(pending), 0);
    chk("reset_step_req", 32'(step_req), 0);
    chk("reset_overrun", 32'(overrun), 0);
    reset = 1'b0;

    // 1: high level at release is not an event
    repeat (20) @(posedge clock);
    #1;
    chk("s1_pending", 32'(pending), 0);
    chk("s1_step_req", 32'(step_req), 0);
    @(negedge clock);

    // 2: single toggle, three-edge latency, then ack
    slow_clk = 1'b0;
    @(posedge clock); #1; chk("s2_k0_pending", 32'(pending), 0);
    @(posedge clock); #1; chk("s2_k1_pending", 32'(pending), 0);
    @(posedge clock); #1;
    chk("s2_k2_pending", 32'(pending), 1);
    chk("s2_k2_step_req", 32'(step_req), 1);
    chk("s2_model_pend", 32'(m_pend), 1);
    @(negedge clock); @(negedge clock); @(negedge clock);
    step_ack = 1'b1;
    @(posedge clock); #1;
    chk("s2_ack_pending", 32'(pending), 0);
    chk("s2_ack_step_req", 32'(step_req), 0);
    @(negedge clock);
    step_ack = 1'b0;

    // 3: saturate, overrun, clear, drain
    for (int i = 0; i < 4; i++) begin
      slow_clk = ~slow_clk;
      repeat (5) @(posedge clock);
      #1;
      chk("s3_pending", 32'(pending), 32'(exp3[i]));
      @(negedge clock);
    end
    chk("s3_overrun_set", 32'(overrun), 1);
    chk("s3_model_ovr", 32'(m_ovr), 1);
    clr_overrun = 1'b1;
    @(negedge clock);
    clr_overrun = 1'b0;
    chk("s3_overrun_clr", 32'(overrun), 0);
    step_ack = 1'b1;
    repeat (3) @(negedge clock);
    step_ack = 1'b0;
    chk("s3_drained", 32'(pending), 0);

    // 4: soft drop, slow edge coinciding with the edge-7 soft event
    soft_drop = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 5) slow_clk = ~slow_clk;
      @(posedge clock); #1;
      if (i == 2)  chk("s4_e2_pending", 32'(pending), 0);
      if (i == 3)  chk("s4_e3_pending", 32'(pending), 1);
      if (i == 7)  chk("s4_e7_pending", 32'(pending), 2);
      if (i == 11) chk("s4_e11_pending", 32'(pending), 3);
      @(negedge clock);
    end
    soft_drop = 1'b0;
    chk("s4_overrun", 32'(overrun), 0);
    chk("s4_model_pend", 32'(m_pend), 3);

    // 5: pause discards events and acks, keeps the queue
    step_ack = 1'b1;
    @(negedge clock);
    step_ack = 1'b0;
    pause    = 1'b1;
    slow_clk = ~slow_clk;
    repeat (5) @(negedge clock);
    slow_clk = ~slow_clk;
    repeat (2) @(negedge clock);
    step_ack = 1'b1;
    @(negedge clock);
    step_ack = 1'b0;
    repeat (4) @(negedge clock);
    chk("s5_pending", 32'(pending), 2);
    chk("s5_step_req", 32'(step_req), 0);
    pause = 1'b0;
    #1;
    chk("s5_unpause_req", 32'(step_req), 1);
    @(negedge clock);

    // 6: event and ack in the same cycle cancel
    step_ack = 1'b1;
    @(negedge clock);
    step_ack = 1'b0;
    slow_clk = ~slow_clk;
    @(negedge clock);
    @(negedge clock);
    step_ack = 1'b1;
    @(posedge clock); #1;
    chk("s6_pending", 32'(pending), 1);
    chk("s6_overrun", 32'(overrun), 0);
    @(negedge clock);
    step_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      slow_clk = ~slow_clk;
      repeat (5) @(negedge clock);
    end
    chk("s6_pre_rst_ovr", 32'(overrun), 1);
    reset = 1'b1;
    #1;
    chk("s6_rst_pending", 32'(pending), 0);
    chk("s6_rst_overrun", 32'(overrun), 0);
    @(negedge clock);
    reset = 1'b0;

    // randomized traffic, checked every cycle by the compare process
    for (int c = 0; c < 4000; c++) begin
      if (reset) reset = 1'b0;
      else if ($urandom_range(499) == 0) reset = 1'b1;
      if ($urandom_range(5) == 0)  slow_clk  = ~slow_clk;
      if ($urandom_range(19) == 0) soft_drop = ~soft_drop;
      if ($urandom_range(29) == 0) pause     = ~pause;
      step_ack    = ($urandom_range(3) == 0);
      clr_overrun = ($urandom_range(15) == 0);
      @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
